result_store: RTL and testbench

- Write-side counterpart of the matrix/vector fetch path.
- On a start pulse, captures the eight-entry result vector C[0:7] produced by the MAC array.
- Drains the captured vector to memory one word per valid/ready write handshake, at consecutive addresses from a base.
- Pulses done when the last write is accepted; sits between the compute array and the memory write port.

---
 rtl/result_store_if.sv | 28 ++
 rtl/result_store.sv | 131 +++++++++++++
 tb/tb_result_store.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_store_if.sv
// Memory write port of the result store: valid/ready handshake carrying address and data.
interface result_store_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 24
);

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Driven by the result store
  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  // Driven by the memory write port
  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/result_store.sv
// Result store: captures the MAC array result vector on start and drains it to
// memory one word per accepted write, at consecutive addresses from BASE_ADDR.
module result_store #(
  parameter int unsigned       N           = 8,
  parameter int unsigned       DATA_W      = 24,
  parameter int unsigned       ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h0040,
  parameter int unsigned       ADDR_STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] C [0:N-1],
  result_store_if.master    wr,
  output logic              busy,
  output logic              done
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] buf_q [0:N-1];
  logic [DATA_W-1:0] buf_d [0:N-1];
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [IDX_W-1:0]  idx_inc_c;

  // Address of entry idx; wraps modulo 2^ADDR_W
  function automatic logic [ADDR_W-1:0] entry_addr(input logic [IDX_W-1:0] idx);
    return BASE_ADDR + ADDR_W'(idx) * ADDR_W'(ADDR_STRIDE);
  endfunction

  assign idx_inc_c = idx_q + IDX_W'(1);

  // Next-state, capture and registered-output logic
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_WRITE;
          buf_d      = C;
          idx_d      = '0;
          wr_valid_d = 1'b1;
          wr_addr_d  = BASE_ADDR;
          wr_data_d  = C[0];
          busy_d     = 1'b1;
        end
      end

      S_WRITE: begin
        // Outputs hold under backpressure; advance only on an accepted write
        if (wr_valid_q && wr.wr_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d    = S_FINISH;
            wr_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else begin
            idx_d     = idx_inc_c;
            wr_addr_d = entry_addr(idx_inc_c);
            wr_data_d = buf_q[idx_inc_c];
          end
        end
      end

      S_FINISH: begin
        // Single-cycle done; any start seen here is dropped
        state_d = S_IDLE;
      end

      default: begin
        state_d    = S_IDLE;
        wr_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Capture buffer; contents are don't-care after reset
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign wr.wr_valid = wr_valid_q;
  assign wr.wr_addr  = wr_addr_q;
  assign wr.wr_data  = wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_result_store.sv
// Self-checking bench for result_store: transaction-level queue model checked every cycle.
module tb_result_store;

  localparam int unsigned       N      = 8;
  localparam int unsigned       DATA_W = 24;
  localparam int unsigned       ADDR_W = 16;
  localparam logic [ADDR_W-1:0] BASE   = 16'h0040;
  localparam int unsigned       STRIDE = 1;

  typedef logic [ADDR_W+DATA_W-1:0] wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [DATA_W-1:0] c_in [0:N-1];
  logic              busy;
  logic              done;

  result_store_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wr_if ();

  result_store #(
    .N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .BASE_ADDR(BASE), .ADDR_STRIDE(STRIDE)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .C     (c_in),
    .wr    (wr_if),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: outstanding writes of the current transaction, in order
  wr_t pend[$];
  wr_t head;
  bit  done_due  = 1'b0;
  bit  model_ok  = 1'b0;
  bit  rst_prev  = 1'b0;
  bit  exp_act;
  int  exp_done_cnt = 0;
  int  done_cnt     = 0;
  int  act_acc      = 0;
  logic [31:0] a_tmp;

  // Compare this cycle's outputs to the model, then advance it for the next edge
  always @(negedge clk) begin
    if (model_ok) begin
      exp_act = (pend.size() != 0);
      check_eq("wr_valid", 32'(wr_if.wr_valid), 32'(exp_act));
      check_eq("busy", 32'(busy), 32'(exp_act));
      check_eq("done", 32'(done), 32'(done_due));
      if (exp_act) begin
        head = pend[0];
        check_eq("wr_addr", 32'(wr_if.wr_addr), 32'(head[ADDR_W+DATA_W-1:DATA_W]));
        check_eq("wr_data", 32'(wr_if.wr_data), 32'(head[DATA_W-1:0]));
      end
      if (rst_prev) begin
        check_eq("rst_addr", 32'(wr_if.wr_addr), 32'd0);
        check_eq("rst_data", 32'(wr_if.wr_data), 32'd0);
      end
    end
    if (done === 1'b1) done_cnt++;
    if (wr_if.wr_valid === 1'b1 && wr_if.wr_ready === 1'b1 && rst === 1'b0) act_acc++;
    rst_prev = (rst === 1'b1);

    if (rst === 1'b1) begin
      pend.delete();
      done_due = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (done_due) begin
        done_due = 1'b0;
      end else if (pend.size() != 0) begin
        if (wr_if.wr_ready === 1'b1) begin
          void'(pend.pop_front());
          if (pend.size() == 0) begin
            done_due = 1'b1;
            exp_done_cnt++;
          end
        end
      end else if (start === 1'b1) begin
        for (int i = 0; i < int'(N); i++) begin
          a_tmp = 32'(BASE) + 32'(i) * 32'(STRIDE);
          pend.push_back({ADDR_W'(a_tmp), c_in[i]});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_c(input logic [DATA_W-1:0] base_val);
    for (int i = 0; i < int'(N); i++) c_in[i] = base_val + DATA_W'(i);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drive wr_ready until done is seen; mode 0: ready high, 1: random with start/C noise,
  // 2: scripted stalls (3 cycles at entry 2, 2 cycles at entry 7). abort_at>0 resets after that many writes.
  task automatic run_txn(input int mode, input int abort_at);
    int base_acc;
    int st2;
    int st7;
    base_acc = act_acc;
    st2 = 0;
    st7 = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (done === 1'b1) begin
        start = 1'b0;
        return;
      end
      if (abort_at > 0 && (act_acc - base_acc) == abort_at) begin
        start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        return;
      end
      case (mode)
        1: begin
          wr_if.wr_ready = ($urandom_range(0, 3) != 0);
          start = ($urandom_range(0, 7) == 0);
          if ($urandom_range(0, 3) == 0) load_c(DATA_W'($urandom));
        end
        2: begin
          wr_if.wr_ready = 1'b1;
          if ((act_acc - base_acc) == 2 && st2 < 3) begin
            wr_if.wr_ready = 1'b0;
            st2++;
          end else if ((act_acc - base_acc) == 7 && st7 < 2) begin
            wr_if.wr_ready = 1'b0;
            st7++;
          end
        end
        default: wr_if.wr_ready = 1'b1;
      endcase
      tick();
    end
    start = 1'b0;
    check_eq("timeout", 32'd0, 32'd1);
  endtask

  int acc0;
  int dn0;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    wr_if.wr_ready = 1'b0;
    load_c('0);
    repeat (3) tick();
    rst = 1'b0;

    // Reset then idle, with wr_ready toggling
    repeat (10) begin
      wr_if.wr_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check_eq("idle_writes", 32'(act_acc), 32'd0);
    check_eq("idle_done", 32'(done_cnt), 32'd0);

    // Basic store
    acc0 = act_acc; dn0 = done_cnt;
    load_c(24'h000100);
    wr_if.wr_ready = 1'b1;
    pulse_start();
    run_txn(0, 0);
    repeat (2) tick();
    check_eq("basic_writes", 32'(act_acc - acc0), 32'd8);
    check_eq("basic_done", 32'(done_cnt - dn0), 32'd1);

    // Backpressure at entries 2 and 7
    acc0 = act_acc; dn0 = done_cnt;
    load_c(24'h000100);
    pulse_start();
    run_txn(2, 0);
    repeat (2) tick();
    check_eq("bp_writes", 32'(act_acc - acc0), 32'd8);
    check_eq("bp_done", 32'(done_cnt - dn0), 32'd1);

    // Capture isolation: C changes after capture, extra start mid-transaction
    acc0 = act_acc; dn0 = done_cnt;
    load_c(24'h000200);
    pulse_start();
    for (int i = 0; i < int'(N); i++) c_in[i] = 24'hFFFFFF;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_txn(0, 0);
    repeat (4) tick();
    check_eq("iso_writes", 32'(act_acc - acc0), 32'd8);
    check_eq("iso_done", 32'(done_cnt - dn0), 32'd1);

    // Back-to-back: start held through FINISH (dropped) and first IDLE cycle (accepted)
    acc0 = act_acc; dn0 = done_cnt;
    load_c(24'h000300);
    pulse_start();
    run_txn(0, 0);
    load_c(24'hABC000);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    run_txn(0, 0);
    repeat (3) tick();
    check_eq("b2b_writes", 32'(act_acc - acc0), 32'd16);
    check_eq("b2b_done", 32'(done_cnt - dn0), 32'd2);

    // Reset after the 4th accepted write, then a clean restart
    acc0 = act_acc; dn0 = done_cnt;
    load_c(24'h000400);
    pulse_start();
    run_txn(0, 4);
    repeat (5) tick();
    check_eq("abort_writes", 32'(act_acc - acc0), 32'd4);
    check_eq("abort_done", 32'(done_cnt - dn0), 32'd0);
    load_c(24'h000500);
    pulse_start();
    run_txn(0, 0);
    repeat (2) tick();
    check_eq("restart_writes", 32'(act_acc - acc0), 32'd12);
    check_eq("restart_done", 32'(done_cnt - dn0), 32'd1);

    // Randomized transactions with random backpressure, start noise and C churn
    acc0 = act_acc; dn0 = done_cnt;
    for (int t = 0; t < 20; t++) begin
      load_c(DATA_W'($urandom));
      pulse_start();
      run_txn(1, 0);
      repeat ($urandom_range(1, 3)) begin
        wr_if.wr_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end
    check_eq("rand_writes", 32'(act_acc - acc0), 32'd160);
    check_eq("rand_done", 32'(done_cnt - dn0), 32'd20);
    check_eq("total_done", 32'(done_cnt), 32'(exp_done_cnt));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
